// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes; signs are re-applied in one FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return {WIDTH{1'b0}} - x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return {(2*WIDTH){1'b0}} - x;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 bzero_q, bzero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div0_q, div0_d;

  logic                 is_signed_s;
  logic                 is_div_op_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_rem_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quo_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;

  // Datapath: operand magnitudes, one iteration step, and sign-corrected results.
  always_comb begin
    is_signed_s = (op == OP_MULT) || (op == OP_DIV);
    is_div_op_s = (op == OP_DIV) || (op == OP_DIVU);
    a_mag_s     = (is_signed_s && a[WIDTH-1]) ? neg_w(a) : a;
    b_mag_s     = (is_signed_s && b[WIDTH-1]) ? neg_w(b) : b;
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    // Partial remainder is WIDTH+1 bits; the true difference always fits back in WIDTH.
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_s    = div_shift_s >= {1'b0, opnd_q};
    div_rem_s   = div_shift_s[WIDTH-1:0] - opnd_q;
    prod_fix_s  = qneg_q ? neg_2w(acc_q) : acc_q;
    quo_fix_s   = qneg_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix_s   = rneg_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the IDLE -> RUN -> FIX sequencer and HI/LO.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d = is_div_op_s;
              qneg_d   = is_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_d   = is_signed_s && a[WIDTH-1];
              bzero_d  = is_div_op_s && (b == {WIDTH{1'b0}});
              // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
              acc_d    = is_div_op_s ? {{WIDTH{1'b0}}, a_mag_s} : {{WIDTH{1'b0}}, b_mag_s};
              opnd_d   = is_div_op_s ? b_mag_s : a_mag_s;
              cnt_d    = {CNT_W{1'b0}};
              busy_d   = 1'b1;
              state_d  = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_ge_s ? {div_rem_s, acc_q[WIDTH-2:0], 1'b1}
                             : {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = acc_q[0] ? {mul_sum_s, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_FIX: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (flush) begin
          done_d = 1'b0;
        end else if (is_div_q) begin
          // Zero divisor: remainder correction restores the original dividend.
          lo_d   = bzero_q ? {WIDTH{1'b1}} : quo_fix_s;
          hi_d   = rem_fix_s;
          done_d = 1'b1;
          div0_d = bzero_q;
        end else begin
          {hi_d, lo_d} = prod_fix_s;
          done_d       = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: WIDTH=32 and WIDTH=8 instances, hand-computed results.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, flush32, busy32, done32, div0_32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, flush8, busy8, done8, div0_8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_checks = 0;
  int n_fail   = 0;
  int nb;
  logic saw_done;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .flush(flush32), .busy(busy32), .done(done32), .div0(div0_32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .div0(div0_8), .hi(hi8), .lo(lo8)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int cnt);
    start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    step;
    start32 = 1'b0; op32 = 3'd0;
    cnt = 0;
    while (busy32 && cnt < 200) begin
      cnt++;
      step;
    end
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output int cnt);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    step;
    start8 = 1'b0; op8 = 3'd0;
    cnt = 0;
    while (busy8 && cnt < 200) begin
      cnt++;
      step;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start32 = 1'b1; op32 = OP_MULT; a32 = 32'd5; b32 = 32'd3; flush32 = 1'b0;
    start8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0; flush8 = 1'b0;
    step;
    step;
    rst = 1'b0; start32 = 1'b0; op32 = 3'd0;
    check_val("rst_hi", hi32, 32'h0);
    check_val("rst_lo", lo32, 32'h0);
    check_val("rst_busy", busy32, 1'b0);
    check_val("rst_done", done32, 1'b0);
    check_val("rst_hi8", hi8, 8'h0);
    step;
    check_val("rst_start_ignored", busy32, 1'b0);

    run32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
    check_val("multu_busy_cycles", nb, 33);
    check_val("multu_done", done32, 1'b1);
    check_val("multu_div0", div0_32, 1'b0);
    check_val("multu_hi", hi32, 32'hFFFFFFFE);
    check_val("multu_lo", lo32, 32'h00000001);
    step;
    check_val("multu_done_pulse", done32, 1'b0);

    run32(OP_MULT, 32'hFFFFFFF9, 32'd3, nb);
    check_val("mult_neg_done", done32, 1'b1);
    check_val("mult_neg_hi", hi32, 32'hFFFFFFFF);
    check_val("mult_neg_lo", lo32, 32'hFFFFFFEB);

    run32(OP_MULT, 32'h80000000, 32'h80000000, nb);
    check_val("mult_minmin_hi", hi32, 32'h40000000);
    check_val("mult_minmin_lo", lo32, 32'h00000000);

    run32(OP_DIV, 32'hFFFFFFF9, 32'd2, nb);
    check_val("div_neg_busy_cycles", nb, 33);
    check_val("div_neg_lo", lo32, 32'hFFFFFFFD);
    check_val("div_neg_hi", hi32, 32'hFFFFFFFF);

    run32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, nb);
    check_val("div_ovf_lo", lo32, 32'h80000000);
    check_val("div_ovf_hi", hi32, 32'h00000000);
    check_val("div_ovf_div0", div0_32, 1'b0);

    run32(OP_DIVU, 32'h00001234, 32'h0, nb);
    check_val("divu_zero_done", done32, 1'b1);
    check_val("divu_zero_div0", div0_32, 1'b1);
    check_val("divu_zero_hi", hi32, 32'h00001234);
    check_val("divu_zero_lo", lo32, 32'hFFFFFFFF);

    run32(OP_DIV, 32'hFFFFFFFB, 32'h0, nb);
    check_val("div_zero_div0", div0_32, 1'b1);
    check_val("div_zero_hi", hi32, 32'hFFFFFFFB);
    check_val("div_zero_lo", lo32, 32'hFFFFFFFF);

    start32 = 1'b1; op32 = OP_MTLO; a32 = 32'hA5A5A5A5;
    step;
    start32 = 1'b0; op32 = 3'd0;
    check_val("mtlo_lo", lo32, 32'hA5A5A5A5);
    check_val("mtlo_hi_kept", hi32, 32'hFFFFFFFB);
    check_val("mtlo_busy", busy32, 1'b0);
    check_val("mtlo_done", done32, 1'b0);

    start32 = 1'b1; op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7;
    step;
    start32 = 1'b0; op32 = 3'd0;
    repeat (4) step;
    start32 = 1'b1; op32 = OP_MTHI; a32 = 32'h55;
    step;
    start32 = 1'b0; op32 = 3'd0;
    check_val("mthi_busy_ignored", hi32, 32'hFFFFFFFB);
    nb = 0;
    while (busy32 && nb < 200) begin
      nb++;
      step;
    end
    check_val("divu_100_7_done", done32, 1'b1);
    check_val("divu_100_7_lo", lo32, 32'd14);
    check_val("divu_100_7_hi", hi32, 32'd2);

    run8(OP_MULT, 8'h80, 8'h80, nb);
    check_val("w8_mult_busy_cycles", nb, 9);
    check_val("w8_mult_hi", hi8, 8'h40);
    check_val("w8_mult_lo", lo8, 8'h00);
    step;

    start8 = 1'b1; op8 = OP_DIVU; a8 = 8'd200; b8 = 8'd3;
    step;
    start8 = 1'b0; op8 = 3'd0;
    repeat (3) step;
    flush8 = 1'b1;
    step;
    flush8 = 1'b0;
    check_val("w8_flush_run_busy", busy8, 1'b0);
    saw_done = done8;
    repeat (12) begin
      step;
      saw_done = saw_done | done8;
    end
    check_val("w8_flush_run_no_done", saw_done, 1'b0);
    check_val("w8_flush_run_hi", hi8, 8'h40);
    check_val("w8_flush_run_lo", lo8, 8'h00);

    start8 = 1'b1; op8 = OP_MTHI; a8 = 8'h77; flush8 = 1'b1;
    step;
    start8 = 1'b0; op8 = 3'd0; flush8 = 1'b0;
    check_val("w8_flush_idle_hi", hi8, 8'h40);
    check_val("w8_flush_idle_busy", busy8, 1'b0);

    start8 = 1'b1; op8 = OP_DIVU; a8 = 8'd9; b8 = 8'd2;
    step;
    start8 = 1'b0; op8 = 3'd0;
    repeat (8) step;
    check_val("w8_fix_still_busy", busy8, 1'b1);
    flush8 = 1'b1;
    step;
    flush8 = 1'b0;
    check_val("w8_flush_fix_done", done8, 1'b0);
    check_val("w8_flush_fix_busy", busy8, 1'b0);
    check_val("w8_flush_fix_lo", lo8, 8'h00);

    run8(OP_DIVU, 8'd200, 8'd3, nb);
    check_val("w8_divu_busy_cycles", nb, 9);
    check_val("w8_divu_done", done8, 1'b1);
    check_val("w8_divu_lo", lo8, 8'd66);
    check_val("w8_divu_hi", hi8, 8'd2);

    run8(OP_DIV, 8'h80, 8'hFF, nb);
    check_val("w8_div_ovf_lo", lo8, 8'h80);
    check_val("w8_div_ovf_hi", hi8, 8'h00);
    step;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
